// File: rtl/throw_sequencer.sv
// throw_sequencer: sequences one ball throw through AIM -> LAUNCH -> FLIGHT -> LANDED -> AIM.
// Optional macro WIND_EN adds a signed wind input that adjusts vx on each frame update.
module throw_sequencer #(
  parameter int START_X       = 32,
  parameter int GROUND_Y      = 440,
  parameter int X_MAX         = 639,
  parameter int GRAV          = 4,
  parameter int TARGET_X      = 176,
  parameter int TARGET_HALF_W = 8,
  parameter int HOLD_FRAMES   = 60
) (
  input  logic              VGA_CLK,
  input  logic              rst,
  input  logic              update,
  input  logic              fire,
  input  logic [3:0]        angle,
  input  logic [3:0]        power,
`ifdef WIND_EN
  input  logic signed [3:0] wind,
`endif
  output logic [9:0]        ball_x,
  output logic [9:0]        ball_y,
  output logic              ball_vis,
  output logic [1:0]        state,
  output logic              aim_lock,
  output logic              hit,
  output logic [7:0]        score
);

  typedef enum logic [1:0] {
    S_AIM    = 2'd0,
    S_LAUNCH = 2'd1,
    S_FLIGHT = 2'd2,
    S_LANDED = 2'd3
  } state_t;

  localparam int HW = $clog2(HOLD_FRAMES + 1);

  localparam logic signed [15:0] START_F   = 16'(START_X * 16);
  localparam logic signed [15:0] GROUND_F  = 16'(GROUND_Y * 16);
  localparam logic signed [11:0] XMAX_S    = 12'(X_MAX);
  localparam logic signed [11:0] GRAV_S    = 12'(GRAV);
  localparam logic signed [12:0] HALF_S    = 13'(TARGET_HALF_W);
  localparam logic [HW-1:0]      HOLD_LAST = HW'(HOLD_FRAMES - 1);

  state_t             r_state;
  logic signed [15:0] r_x_f;
  logic signed [15:0] r_y_f;
  logic signed [11:0] r_vx;
  logic signed [11:0] r_vy;
  logic [HW-1:0]      r_hold;
  logic               r_fire_q;
  logic               r_vis;
  logic               r_aim_lock;
  logic               r_hit;
  logic [7:0]         r_score;

  logic [4:0]         w_p1;
  logic [4:0]         w_a_lo;
  logic [4:0]         w_a_hi;
  logic [9:0]         w_vx_l;
  logic [9:0]         w_vy_l;
  logic signed [15:0] w_vx_ext;
  logic signed [15:0] w_vy_ext;
  logic signed [15:0] w_nx;
  logic signed [15:0] w_ny;
  logic signed [11:0] w_nx_px;
  logic signed [12:0] w_dx;
  logic               w_land;
  logic               w_oob;
  logic               w_in_tgt;
  logic               w_fire_edge;

  // Launch velocity: flatter angles trade vertical speed for horizontal speed.
  assign w_p1   = {1'b0, power} + 5'd1;
  assign w_a_lo = 5'd16 - {1'b0, angle};
  assign w_a_hi = {1'b0, angle} + 5'd1;
  assign w_vx_l = {5'd0, w_p1} * {5'd0, w_a_lo};
  assign w_vy_l = {5'd0, w_p1} * {5'd0, w_a_hi};

  // One frame of integration from the current (old) position and velocity.
  assign w_vx_ext = {{4{r_vx[11]}}, r_vx};
  assign w_vy_ext = {{4{r_vy[11]}}, r_vy};
  assign w_nx     = r_x_f + w_vx_ext;
  assign w_ny     = r_y_f - w_vy_ext;
  assign w_nx_px  = w_nx[15:4];
  assign w_dx     = {w_nx_px[11], w_nx_px} - 13'(TARGET_X);

  assign w_land      = (w_ny >= GROUND_F);
  assign w_oob       = (w_nx_px > XMAX_S);
  assign w_in_tgt    = (w_dx <= HALF_S) && (w_dx >= -HALF_S);
  assign w_fire_edge = fire && !r_fire_q;

`ifdef WIND_EN
  logic signed [11:0] w_vx_wind;
  assign w_vx_wind = r_vx + {{8{wind[3]}}, wind};
`endif

  always_ff @(posedge VGA_CLK) begin
    r_hit    <= 1'b0;
    r_fire_q <= fire;
    if (rst) begin
      r_state    <= S_AIM;
      r_x_f      <= START_F;
      r_y_f      <= GROUND_F;
      r_vx       <= '0;
      r_vy       <= '0;
      r_hold     <= '0;
      r_fire_q   <= 1'b0;
      r_vis      <= 1'b1;
      r_aim_lock <= 1'b0;
      r_score    <= '0;
    end else begin
      case (r_state)
        S_AIM: begin
          r_x_f <= START_F;
          r_y_f <= GROUND_F;
          r_vis <= 1'b1;
          if (w_fire_edge) begin
            r_state    <= S_LAUNCH;
            r_aim_lock <= 1'b1;
          end
        end

        S_LAUNCH: begin
          r_vx    <= {2'b00, w_vx_l};
          r_vy    <= {2'b00, w_vy_l};
          r_x_f   <= START_F;
          r_y_f   <= GROUND_F;
          r_vis   <= 1'b1;
          r_state <= S_FLIGHT;
        end

        S_FLIGHT: begin
          if (update) begin
            r_x_f <= w_nx;
            r_vy  <= r_vy - GRAV_S;
`ifdef WIND_EN
            // Wind may slow the ball to a stop but never throws it backwards.
            r_vx  <= w_vx_wind[11] ? 12'sd0 : w_vx_wind;
`endif
            if (w_land) begin
              r_y_f   <= GROUND_F;
              r_vis   <= 1'b1;
              r_state <= S_LANDED;
              if (w_in_tgt) begin
                r_hit   <= 1'b1;
                r_score <= r_score + 8'd1;
              end
            end else begin
              r_y_f <= w_ny;
              if (w_oob) begin
                r_vis   <= 1'b0;
                r_state <= S_LANDED;
              end else begin
                r_vis <= !w_ny[15];
              end
            end
          end
        end

        S_LANDED: begin
          if (update) begin
            if (r_hold == HOLD_LAST) begin
              r_hold     <= '0;
              r_x_f      <= START_F;
              r_y_f      <= GROUND_F;
              r_vis      <= 1'b1;
              r_aim_lock <= 1'b0;
              r_state    <= S_AIM;
            end else begin
              r_hold <= r_hold + HW'(1);
            end
          end
        end

        default: begin
          r_state    <= S_AIM;
          r_aim_lock <= 1'b0;
        end
      endcase
    end
  end

  assign ball_x   = r_x_f[13:4];
  assign ball_y   = r_y_f[15] ? 10'd0 : r_y_f[13:4];
  assign ball_vis = r_vis;
  assign state    = r_state;
  assign aim_lock = r_aim_lock;
  assign hit      = r_hit;
  assign score    = r_score;

endmodule

// File: tb/tb_throw_sequencer.sv
// Bench for throw_sequencer: default-gravity and GRAV=1 instances driven by shared random stimulus.
// Each instance is compared every cycle against a frame-level throw model; WIND_EN adds wind.
module tb_throw_sequencer;

  localparam int START_X  = 32;
  localparam int GROUND_Y = 440;
  localparam int X_MAX    = 639;
  localparam int TARGET_X = 176;
  localparam int HALF_W   = 8;
  localparam int HOLD     = 60;
  localparam int GRAVS [2] = '{4, 1};

  logic VGA_CLK = 1'b0;
  logic rst = 1'b1, update = 1'b0, fire = 1'b0;
  logic [3:0] angle = 4'd0, power = 4'd0;
`ifdef WIND_EN
  logic signed [3:0] wind = 4'sd0;
`endif

  logic [9:0] bx [2];
  logic [9:0] by [2];
  logic       vis [2];
  logic [1:0] st [2];
  logic       lk [2];
  logic       ht [2];
  logic [7:0] sc [2];

  int n_checks = 0;
  int n_err    = 0;

  // model state, one set per instance
  int m_ph [2], m_x [2], m_y [2], m_vx [2], m_vy [2], m_hold [2], m_score [2];
  bit m_oob [2], m_hit [2], m_pf [2];

  always #5 VGA_CLK = ~VGA_CLK;

  throw_sequencer dut (
    .VGA_CLK(VGA_CLK), .rst(rst), .update(update), .fire(fire),
    .angle(angle), .power(power),
`ifdef WIND_EN
    .wind(wind),
`endif
    .ball_x(bx[0]), .ball_y(by[0]), .ball_vis(vis[0]), .state(st[0]),
    .aim_lock(lk[0]), .hit(ht[0]), .score(sc[0])
  );

  throw_sequencer #(.GRAV(1)) dut_g1 (
    .VGA_CLK(VGA_CLK), .rst(rst), .update(update), .fire(fire),
    .angle(angle), .power(power),
`ifdef WIND_EN
    .wind(wind),
`endif
    .ball_x(bx[1]), .ball_y(by[1]), .ball_vis(vis[1]), .state(st[1]),
    .aim_lock(lk[1]), .hit(ht[1]), .score(sc[1])
  );

  task automatic check_eq(string tag, int got, int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_step(int k);
    m_hit[k] = 1'b0;
    if (rst) begin
      m_ph[k] = 0; m_x[k] = START_X * 16; m_y[k] = GROUND_Y * 16;
      m_vx[k] = 0; m_vy[k] = 0; m_hold[k] = 0; m_score[k] = 0;
      m_oob[k] = 1'b0; m_pf[k] = 1'b0;
      return;
    end
    case (m_ph[k])
      0: if (fire && !m_pf[k]) m_ph[k] = 1;
      1: begin
        m_vx[k] = (int'(power) + 1) * (16 - int'(angle));
        m_vy[k] = (int'(power) + 1) * (int'(angle) + 1);
        m_x[k]  = START_X * 16;
        m_y[k]  = GROUND_Y * 16;
        m_ph[k] = 2;
      end
      2: if (update) begin
        m_x[k]  = m_x[k] + m_vx[k];
        m_y[k]  = m_y[k] - m_vy[k];
        m_vy[k] = m_vy[k] - GRAVS[k];
`ifdef WIND_EN
        m_vx[k] = m_vx[k] + int'(wind);
        if (m_vx[k] < 0) m_vx[k] = 0;
`endif
        if (m_y[k] >= GROUND_Y * 16) begin
          m_y[k]  = GROUND_Y * 16;
          m_ph[k] = 3;
          if ((m_x[k] / 16 - TARGET_X) <= HALF_W && (TARGET_X - m_x[k] / 16) <= HALF_W) begin
            m_hit[k]   = 1'b1;
            m_score[k] = (m_score[k] + 1) % 256;
          end
        end else if (m_x[k] / 16 > X_MAX) begin
          m_ph[k]  = 3;
          m_oob[k] = 1'b1;
        end
      end
      default: if (update) begin
        m_hold[k]++;
        if (m_hold[k] == HOLD) begin
          m_hold[k] = 0; m_x[k] = START_X * 16; m_y[k] = GROUND_Y * 16;
          m_oob[k] = 1'b0; m_ph[k] = 0;
        end
      end
    endcase
    m_pf[k] = fire;
  endtask

  task automatic compare_all(int k);
    string p;
    p = (k == 0) ? "g4" : "g1";
    check_eq({p, ".state"},    int'(st[k]),  m_ph[k]);
    check_eq({p, ".ball_x"},   int'(bx[k]),  (m_x[k] / 16) % 1024);
    check_eq({p, ".ball_y"},   int'(by[k]),  (m_y[k] < 0) ? 0 : m_y[k] / 16);
    check_eq({p, ".ball_vis"}, int'(vis[k]), (m_oob[k] || m_y[k] < 0) ? 0 : 1);
    check_eq({p, ".aim_lock"}, int'(lk[k]),  (m_ph[k] != 0) ? 1 : 0);
    check_eq({p, ".hit"},      int'(ht[k]),  int'(m_hit[k]));
    check_eq({p, ".score"},    int'(sc[k]),  m_score[k]);
  endtask

  task automatic tick();
    @(posedge VGA_CLK);
    model_step(0);
    model_step(1);
    #1;
    compare_all(0);
    compare_all(1);
  endtask

  initial begin
    int n_upd;
    bit got_flight;

    // reset held three cycles
    rst = 1'b1;
    repeat (3) tick();
    check_eq("rst.state", int'(st[0]), 0);
    check_eq("rst.ball_x", int'(bx[0]), 32);
    check_eq("rst.ball_y", int'(by[0]), 440);
    check_eq("rst.vis", int'(vis[0]), 1);
    check_eq("rst.score", int'(sc[0]), 0);
    check_eq("rst.lock", int'(lk[0]), 0);
    rst = 1'b0;
    tick();

    // flat full-power throw lands on the target after nine frames
    angle = 4'd0; power = 4'd15; fire = 1'b1;
    tick();
    check_eq("dir.launch", int'(st[0]), 1);
    tick();
    check_eq("dir.flight", int'(st[0]), 2);
    n_upd = 0;
    repeat (9) begin
      update = 1'b1; tick(); n_upd++;
      if (n_upd == 1) begin
        check_eq("dir.u1_x", int'(bx[0]), 48);
        check_eq("dir.u1_y", int'(by[0]), 439);
      end
      if (n_upd == 4) check_eq("dir.u4_y", int'(by[0]), 437);
      update = 1'b0; tick();
      if (n_upd == 9) check_eq("dir.hit_once", int'(ht[0]), 0);
    end
    check_eq("dir.landed", int'(st[0]), 3);
    check_eq("dir.land_x", int'(bx[0]), 176);
    check_eq("dir.land_y", int'(by[0]), 440);
    check_eq("dir.score", int'(sc[0]), 1);

    // hold for 60 frames with fire held high: returns to AIM, no relaunch
    for (int i = 1; i <= HOLD; i++) begin
      update = 1'b1; tick();
      if (i == HOLD - 1) check_eq("hold.59", int'(st[0]), 3);
    end
    update = 1'b0;
    check_eq("hold.aim", int'(st[0]), 0);
    check_eq("hold.x", int'(bx[0]), 32);
    repeat (3) tick();
    check_eq("hold.norelaunch", int'(st[0]), 0);

    // fresh edge together with update in AIM
    fire = 1'b0; tick();
    fire = 1'b1; update = 1'b1; tick();
    check_eq("sim.launch", int'(st[0]), 1);
    check_eq("sim.pos_x", int'(bx[0]), 32);
    update = 1'b0;

    // randomized play
    for (int c = 0; c < 16000; c++) begin
      update = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 19) == 0) fire = ~fire;
      if ($urandom_range(0, 7) == 0) angle = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) power = 4'($urandom_range(0, 15));
`ifdef WIND_EN
      if ($urandom_range(0, 3) == 0) wind = 4'($urandom_range(0, 15));
`endif
      rst = ($urandom_range(0, 3999) == 0);
      tick();
    end
    rst = 1'b0;

    // reset in the middle of a flight
    got_flight = 1'b0;
    for (int c = 0; c < 3000 && !got_flight; c++) begin
      fire = ~fire;
      update = ($urandom_range(0, 1) == 0);
      tick();
      if (st[0] == 2'd2) got_flight = 1'b1;
    end
    check_eq("mid.reached_flight", int'(got_flight), 1);
    update = 1'b1; fire = 1'b0; tick();
    rst = 1'b1; update = 1'b0; tick();
    check_eq("mid.state", int'(st[0]), 0);
    check_eq("mid.x", int'(bx[0]), 32);
    check_eq("mid.y", int'(by[0]), 440);
    check_eq("mid.score", int'(sc[0]), 0);
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
